// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo
// Pairs per-channel words from the I2S receiver into left/right stereo
// frames, buffers them in a first-word-fall-through FIFO and presents them
// to the mixer over a valid/ready handshake. Single clock domain (sck).
//
// Optional feature macro: I2S_FRAME_FIFO_OVF_CNT_EN
//   When defined, adds the ovf_count port: a saturating 8-bit count of
//   dropped frames, cleared only by rst.
//
// Ports:
//   sck          - bit clock, all logic on the rising edge
//   rst          - synchronous, active-high reset
//   data_in      - completed word from the receiver
//   left_rightn  - 1 = left word, 0 = right word
//   data_en      - one-cycle strobe, word valid this cycle
//   frame_valid  - FIFO head holds a frame
//   frame_ready  - consumer accepts the head this cycle
//   frame_left   - head left sample (0 when empty)
//   frame_right  - head right sample (0 when empty)
//   fifo_level   - number of stored frames, 0..2**DEPTH_LOG2
//   overflow     - one-cycle pulse, a completed frame was dropped
//   ovf_count    - saturating overflow count (macro builds only)
module i2s_frame_fifo #(
  parameter int BITS_PRECISION = 4,
  parameter int DEPTH_LOG2     = 2
) (
  input  logic                      sck,
  input  logic                      rst,
  input  logic [BITS_PRECISION-1:0] data_in,
  input  logic                      left_rightn,
  input  logic                      data_en,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [BITS_PRECISION-1:0] frame_left,
  output logic [BITS_PRECISION-1:0] frame_right,
  output logic [DEPTH_LOG2:0]       fifo_level,
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
  output logic                      overflow,
  output logic [7:0]                ovf_count
`else
  output logic                      overflow
`endif
);

  localparam int MSB   = BITS_PRECISION - 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  // A depth-1 FIFO still needs a 1-bit pointer; it simply never leaves 0.
  localparam int PTR_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  typedef enum logic {
    WAIT_LEFT  = 1'b0,
    WAIT_RIGHT = 1'b1
  } pair_state_t;

  pair_state_t               state;
  logic [MSB:0]              held_left;
  logic [2*BITS_PRECISION-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;

  logic push_req;
  logic pop;
  logic full;
  logic do_write;
  logic drop;
  logic [2*BITS_PRECISION-1:0] head;

  // Wrap modulo DEPTH rather than relying on natural overflow so that the
  // DEPTH_LOG2 = 0 case behaves correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign push_req    = (state == WAIT_RIGHT) && data_en && !left_rightn;
  assign frame_valid = (fifo_level != '0);
  assign pop         = frame_valid && frame_ready;
  assign full        = (fifo_level == LVL_W'(DEPTH));
  // When full, a same-cycle pop frees the head slot, which is exactly where
  // wr_ptr points, so the new frame lands behind everything still queued.
  assign do_write    = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;

  assign head        = mem[rd_ptr];
  assign frame_left  = frame_valid ? head[2*BITS_PRECISION-1:BITS_PRECISION] : '0;
  assign frame_right = frame_valid ? head[MSB:0] : '0;

  always_ff @(posedge sck) begin
    if (rst) begin
      state     <= WAIT_LEFT;
      held_left <= '0;
    end else if (data_en) begin
      unique case (state)
        WAIT_LEFT: begin
          if (left_rightn) begin
            held_left <= data_in;
            state     <= WAIT_RIGHT;
          end
        end
        WAIT_RIGHT: begin
          if (left_rightn) begin
            held_left <= data_in;
          end else begin
            state <= WAIT_LEFT;
          end
        end
        default: state <= WAIT_LEFT;
      endcase
    end
  end

  // Frame storage deliberately has no reset.
  always_ff @(posedge sck) begin
    if (!rst && do_write) begin
      mem[wr_ptr] <= {held_left, data_in};
    end
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= drop;
      if (do_write) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_write, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
  always_ff @(posedge sck) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (drop && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_frame_fifo.sv
// tb_i2s_frame_fifo
// Self-checking bench for i2s_frame_fifo (BITS_PRECISION=4, DEPTH_LOG2=2).
// Table-driven vectors cover pairing and basic handshake; hand-written
// sequences cover overflow, full push+pop, pointer wrap, mid-run reset and
// (with I2S_FRAME_FIFO_OVF_CNT_EN) counter saturation.
module tb_i2s_frame_fifo;

  logic       sck;
  logic       rst;
  logic [3:0] data_in;
  logic       left_rightn;
  logic       data_en;
  logic       frame_valid;
  logic       frame_ready;
  logic [3:0] frame_left;
  logic [3:0] frame_right;
  logic [2:0] fifo_level;
  logic       overflow;
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  i2s_frame_fifo #(
    .BITS_PRECISION(4),
    .DEPTH_LOG2    (2)
  ) dut (
    .sck        (sck),
    .rst        (rst),
    .data_in    (data_in),
    .left_rightn(left_rightn),
    .data_en    (data_en),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_left (frame_left),
    .frame_right(frame_right),
    .fifo_level (fifo_level),
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
    .overflow   (overflow),
    .ovf_count  (ovf_count)
`else
    .overflow   (overflow)
`endif
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  typedef struct packed {
    logic       en;
    logic       lr;
    logic [3:0] d;
    logic       rdy;
    logic       valid;
    logic [3:0] l;
    logic [3:0] r;
    logic [2:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs [15];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic valid, input logic [3:0] l,
                             input logic [3:0] r, input logic [2:0] lvl, input logic ovf);
    checkVal($sformatf("%s.valid", name), 32'(frame_valid), 32'(valid));
    checkVal($sformatf("%s.left", name),  32'(frame_left),  32'(l));
    checkVal($sformatf("%s.right", name), 32'(frame_right), 32'(r));
    checkVal($sformatf("%s.level", name), 32'(fifo_level),  32'(lvl));
    checkVal($sformatf("%s.ovf", name),   32'(overflow),    32'(ovf));
  endtask

  // Drive one cycle of inputs, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic en, input logic lr, input logic [3:0] d, input logic rdy);
    data_en     = en;
    left_rightn = lr;
    data_in     = d;
    frame_ready = rdy;
    @(posedge sck);
    #1;
    data_en     = 1'b0;
    frame_ready = 1'b0;
  endtask

  task automatic pushFrame(input logic [3:0] l, input logic [3:0] r, input logic rdy_on_right);
    applyStimulus(1'b1, 1'b1, l, 1'b0);
    applyStimulus(1'b1, 1'b0, r, rdy_on_right);
  endtask

  task automatic popFrame();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    rst         = 1'b1;
    data_in     = 4'h0;
    left_rightn = 1'b0;
    data_en     = 1'b0;
    frame_ready = 1'b0;

    //        en    lr    d      rdy   valid l      r      lvl   ovf
    vecs[0]  = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 4'h3, 4'hC, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 4'h2, 4'h7, 3'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h2, 4'h7, 3'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'hB, 1'b0, 1'b1, 4'hA, 4'hB, 3'd1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 4'hA, 4'hB, 3'd1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'h5, 1'b1, 1'b1, 4'h4, 4'h5, 3'd1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0};

    // Reset
    repeat (2) @(posedge sck);
    #1;
    rst = 1'b0;
    checkOutput("reset", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
    checkVal("reset.ovf_count", 32'(ovf_count), 32'd0);
`endif

    // Pairing, orphan handling, handshake
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].en, vecs[i].lr, vecs[i].d, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].valid, vecs[i].l, vecs[i].r,
                  vecs[i].lvl, vecs[i].ovf);
    end

    // Overflow: five frames into a four-deep FIFO with no consumer
    for (int i = 1; i <= 5; i++) begin
      pushFrame(4'(i), 4'(i + 8), 1'b0);
      checkVal($sformatf("ovf_fill%0d.level", i), 32'(fifo_level), (i < 5) ? i : 4);
      checkVal($sformatf("ovf_fill%0d.ovf", i), 32'(overflow), (i == 5) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkVal("ovf_idle.ovf", 32'(overflow), 32'd0);
    checkVal("ovf_idle.level", 32'(fifo_level), 32'd4);
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
    checkVal("ovf_idle.ovf_count", 32'(ovf_count), 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("ovf_drain%0d", i), 1'b1, 4'(i), 4'(i + 8), 3'(5 - i), 1'b0);
      popFrame();
    end
    checkOutput("ovf_empty", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);

    // Full FIFO: completing push on the same cycle as a pop
    for (int i = 1; i <= 4; i++) pushFrame(4'(i), 4'(15 - i), 1'b0);
    checkVal("full.level", 32'(fifo_level), 32'd4);
    pushFrame(4'h5, 4'hA, 1'b1);
    checkOutput("full_pushpop", 1'b1, 4'h2, 4'hD, 3'd4, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      checkOutput($sformatf("full_drain%0d", i), 1'b1, 4'(i), 4'(15 - i), 3'(6 - i), 1'b0);
      popFrame();
    end
    checkOutput("full_empty", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);

    // Pointer wrap over 10 frames
    for (int k = 0; k < 10; k++) begin
      pushFrame(4'(k), 4'(15 - k), 1'b0);
      checkOutput($sformatf("wrap%0d", k), 1'b1, 4'(k), 4'(15 - k), 3'd1, 1'b0);
      popFrame();
    end

    // Mid-run reset with held left and two stored frames
    pushFrame(4'h6, 4'h9, 1'b0);
    pushFrame(4'h7, 4'h8, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'hE, 1'b0);
    checkVal("prerst.level", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h9, 1'b0);
    rst = 1'b0;
    checkOutput("midrst", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
    checkVal("midrst.ovf_count", 32'(ovf_count), 32'd0);
`endif
    applyStimulus(1'b1, 1'b0, 4'h3, 1'b0);
    checkOutput("postrst_orphan", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);

    // 300 forced overflows
    for (int i = 0; i < 4; i++) pushFrame(4'(i), 4'(i), 1'b0);
    for (int i = 0; i < 300; i++) begin
      pushFrame(4'hF, 4'hF, 1'b0);
      if (i < 3 || i == 299) begin
        checkVal($sformatf("sat%0d.ovf", i), 32'(overflow), 32'd1);
        checkVal($sformatf("sat%0d.level", i), 32'(fifo_level), 32'd4);
      end
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkVal("sat_idle.ovf", 32'(overflow), 32'd0);
`ifdef I2S_FRAME_FIFO_OVF_CNT_EN
    checkVal("sat.ovf_count", 32'(ovf_count), 32'd255);
`endif
    checkOutput("sat_head", 1'b1, 4'h0, 4'h0, 3'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_frame_fifo.md
# i2s_frame_fifo

Stereo frame assembler and buffer directly downstream of the I2S input receiver. Pairs the receiver's per-channel words (`data_in`, `left_rightn`, `data_en`) into left/right stereo frames, stores them in a small first-word-fall-through FIFO, and presents them to the mixer core over a valid/ready handshake. Runs entirely in the `sck` domain; no clock crossing.

## Interface
- `BITS_PRECISION`, default 4: sample width in bits; `MSB = BITS_PRECISION-1`.
- `DEPTH_LOG2`, default 2: FIFO depth is `2**DEPTH_LOG2` frames (minimum 1).

- `sck` in 1: bit clock; all logic on rising edge.
- `rst` in 1: reset rst, synchronous, active-high.
- `data_in` in BITS_PRECISION: completed word from the receiver.
- `left_rightn` in 1: 1 = left-channel word, 0 = right-channel word.
- `data_en` in 1: one-cycle strobe, word valid this cycle.
- `frame_valid` out 1: FIFO head holds a frame.
- `frame_ready` in 1: consumer accepts head this cycle.
- `frame_left` out BITS_PRECISION: head left sample.
- `frame_right` out BITS_PRECISION: head right sample.
- `fifo_level` out DEPTH_LOG2+1: frames stored, 0..2**DEPTH_LOG2.
- `overflow` out 1: one-cycle pulse, a completed frame was dropped.
- `ovf_count` out 8: only with `I2S_FRAME_FIFO_OVF_CNT_EN`; see Configuration.

## Operation
- Pairing FSM, states WAIT_LEFT, WAIT_RIGHT; reset state WAIT_LEFT.
- WAIT_LEFT, `data_en && left_rightn`: latch `data_in` as held left, go WAIT_RIGHT.
- WAIT_LEFT, `data_en && !left_rightn`: discard word (orphan right), stay.
- WAIT_RIGHT, `data_en && !left_rightn`: push `{held left, data_in}`, go WAIT_LEFT.
- WAIT_RIGHT, `data_en && left_rightn`: overwrite held left with new word, stay (previous left discarded).
- No `data_en`: state and held left unchanged.
- FIFO: circular buffer, read/write pointers DEPTH_LOG2 bits wrapping modulo depth; `fifo_level` tracks occupancy.
- Pop when `frame_valid && frame_ready`; `frame_ready` while empty is ignored.
- Push while not full: stored. Push while full with same-cycle pop: both performed, level stays full, no overflow. Push while full without pop: frame dropped, pointers unchanged, `overflow`=1 for that cycle.
- Push and pop on same cycle when not full/empty: level unchanged.
- `frame_left`/`frame_right` read the head combinationally from storage and are forced to 0 whenever `frame_valid`=0.
- Storage array is not reset; only control state is.

## Timing
- Reset values: `frame_valid`=0, `frame_left`=0, `frame_right`=0, `fifo_level`=0, `overflow`=0, `ovf_count`=0, FSM WAIT_LEFT, pointers 0.
- `rst` mid-operation: all buffered frames and any held left discarded on that edge; input `data_en` during `rst` is ignored.
- Latency: right-word `data_en` sampled at edge N -> `frame_valid`=1 and head data visible after edge N (cycle N+1) if FIFO was empty.
- Pop at edge N -> next frame (or `frame_valid`=0) visible after edge N.
- `fifo_level` and `overflow` registered, updated on the same edge as the push/pop.
- Inputs `data_in`/`left_rightn` only sampled when `data_en`=1.

## Configuration
- `I2S_FRAME_FIFO_OVF_CNT_EN` defined: port `ovf_count` exists; increments by 1 on each `overflow` pulse, saturates at 255, cleared only by `rst`.
- Not defined: `ovf_count` port and counter absent; `overflow` pulse behaviour identical.

## Test plan
- Reset, then L=0x3 then R=0xC strobes -> one cycle after R strobe: `frame_valid`=1, `frame_left`=0x3, `frame_right`=0xC, `fifo_level`=1; pop with `frame_ready`=1 -> `frame_valid`=0, outputs 0, level 0.
- Orphan R=0x5, then L=0x1, L=0x2, R=0x7 -> exactly one frame {0x2,0x7}; no overflow.
- `frame_ready`=0, push 5 frames with DEPTH_LOG2=2 -> level 4, fifth frame dropped, `overflow` one cycle, `ovf_count`=1 (macro on); drain yields frames 1-4 in order.
- Full FIFO, completing push on same cycle as pop -> level stays 4, no overflow, new frame appears last after draining; pointer wrap verified over 10 frames.
- Held left and 2 stored frames, assert `rst` one cycle -> level 0, `frame_valid`=0; next R strobe alone produces no frame.
- Macro on, 300 forced overflows -> `ovf_count` holds 255.
